fp_accumulator: RTL and testbench

FP_ACCUMULATOR -- requirements
Module: fp_accumulator

---
 rtl/fp_acc_pkg.sv | 13 +
 rtl/fp_accumulator_add_sub.sv | 100 ++++++++++
 rtl/fp_accumulator.sv | 89 ++++++++
 tb/tb_fp_accumulator.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fp_acc_pkg.sv
// Shared types and constants for the floating-point packet accumulator.
package fp_acc_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_t;

    localparam int FP_W     = 32;
    localparam int SIGN_BIT = 31;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
endpackage

// File: rtl/fp_accumulator_add_sub.sv
// Combinational IEEE-754 single-precision add/subtract, round-to-nearest-even,
// with gradual underflow; o_underflow marks a nonzero subnormal result.
module fp_accumulator_add_sub
    import fp_acc_pkg::*;
(
    input  logic [FP_W-1:0] i_a,
    input  logic [FP_W-1:0] i_b,
    input  logic            i_sub,
    output logic [FP_W-1:0] o_sum,
    output logic            o_overflow,
    output logic            o_underflow
);
    logic             w_sa, w_sb, w_sx, w_sy;
    logic [EXP_W-1:0] w_ea, w_eb, w_ex, w_ey, w_d, w_shl;
    logic [MAN_W:0]   w_ma, w_mb, w_mx, w_my;
    logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_swap, w_rnd, w_tiny;
    logic [26:0]      w_yal, w_m;
    logic [27:0]      w_s;
    logic [4:0]       w_msb, w_lz;
    logic [8:0]       w_e;
    logic [31:0]      w_pack;

    assign w_sa    = i_a[SIGN_BIT];
    assign w_sb    = i_b[SIGN_BIT] ^ i_sub;
    assign w_a_nan = (i_a[30:23] == 8'hFF) && (i_a[22:0] != '0);
    assign w_b_nan = (i_b[30:23] == 8'hFF) && (i_b[22:0] != '0);
    assign w_a_inf = (i_a[30:23] == 8'hFF) && (i_a[22:0] == '0);
    assign w_b_inf = (i_b[30:23] == 8'hFF) && (i_b[22:0] == '0);

    always_comb begin
        // subnormals use exponent 1 with no hidden bit
        w_ea   = (i_a[30:23] == '0) ? 8'd1 : i_a[30:23];
        w_eb   = (i_b[30:23] == '0) ? 8'd1 : i_b[30:23];
        w_ma   = {(i_a[30:23] != '0), i_a[22:0]};
        w_mb   = {(i_b[30:23] != '0), i_b[22:0]};
        w_swap = i_b[30:0] > i_a[30:0];
        w_sx   = w_swap ? w_sb : w_sa;
        w_sy   = w_swap ? w_sa : w_sb;
        w_ex   = w_swap ? w_eb : w_ea;
        w_ey   = w_swap ? w_ea : w_eb;
        w_mx   = w_swap ? w_mb : w_ma;
        w_my   = w_swap ? w_ma : w_mb;
        w_d    = w_ex - w_ey;

        if (w_d >= 8'd27) begin
            w_yal = {26'd0, |w_my};
        end else begin
            w_yal    = {w_my, 3'b000} >> w_d;
            w_yal[0] = w_yal[0] | (|({w_my, 3'b000} & ~(27'h7FFFFFF << w_d)));
        end

        if (w_sx == w_sy) w_s = {1'b0, w_mx, 3'b000} + {1'b0, w_yal};
        else              w_s = {1'b0, w_mx, 3'b000} - {1'b0, w_yal};

        w_msb = '0;
        for (int i = 0; i < 27; i++) begin
            if (w_s[i]) w_msb = i[4:0];
        end
        w_lz  = 5'd26 - w_msb;
        w_shl = '0;

        if (w_s[27]) begin
            w_m = w_s[27:1] | {26'd0, w_s[0]};
            w_e = {1'b0, w_ex} + 9'd1;
        end else begin
            // left shift stops at the subnormal boundary
            if ({3'b000, w_lz} < w_ex) begin
                w_shl = {3'b000, w_lz};
                w_e   = {1'b0, w_ex} - {4'b0000, w_lz};
            end else begin
                w_shl = w_ex - 8'd1;
                w_e   = '0;
            end
            w_m = w_s[26:0] << w_shl;
        end

        w_rnd  = w_m[2] & (w_m[3] | w_m[1] | w_m[0]);
        // fraction carry rolls straight into the exponent field
        w_pack = {w_e, w_m[25:3]} + {31'd0, w_rnd};
        w_tiny = ~w_m[26] & (w_pack[31:23] == 9'd0);

        o_sum       = {w_sx, w_pack[30:0]};
        o_overflow  = 1'b0;
        o_underflow = 1'b0;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb))) begin
            o_sum = 32'h7FC00000;
        end else if (w_a_inf) begin
            o_sum = {w_sa, 8'hFF, 23'd0};
        end else if (w_b_inf) begin
            o_sum = {w_sb, 8'hFF, 23'd0};
        end else if (w_s == '0) begin
            o_sum = {w_sa & w_sb, 31'd0};
        end else if (w_pack[31:23] >= 9'd255) begin
            o_sum      = {w_sx, 8'hFF, 23'd0};
            o_overflow = 1'b1;
        end else begin
            o_underflow = w_tiny;
        end
    end
endmodule

// File: rtl/fp_accumulator.sv
// Packet accumulator: sums a stream of FP32 elements (add or subtract each),
// then holds the result with count and sticky flags until it is taken.
module fp_accumulator
    import fp_acc_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FP_W-1:0]  in_data,
    input  logic             in_sub,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FP_W-1:0]  out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_overflow,
    output logic             out_underflow
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    acc_state_t       r_state, w_state_nxt;
    logic             r_run;
    logic [FP_W-1:0]  r_acc;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf, r_unf;
    logic             w_in_ready, w_accept;
    logic [FP_W-1:0]  w_sum;
    logic             w_ovf, w_unf;

    fp_accumulator_add_sub u_add_sub (
        .i_a         (r_acc),
        .i_b         (in_data),
        .i_sub       (in_sub),
        .o_sum       (w_sum),
        .o_overflow  (w_ovf),
        .o_underflow (w_unf)
    );

    // r_run keeps in_ready low until the first edge after reset releases
    assign w_in_ready = r_run && (r_state != HOLD);
    assign w_accept   = in_valid && w_in_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = in_last ? HOLD : ACCUM;
            ACCUM:   if (w_accept && in_last) w_state_nxt = HOLD;
            HOLD:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_run   <= 1'b0;
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_run   <= 1'b1;
            r_state <= w_state_nxt;
            if (w_accept) begin
                if (r_state == IDLE) begin
                    r_acc   <= {in_data[SIGN_BIT] ^ in_sub, in_data[SIGN_BIT-1:0]};
                    r_count <= CNT_W'(1);
                    r_ovf   <= 1'b0;
                    r_unf   <= 1'b0;
                end else begin
                    r_acc <= w_sum;
                    r_ovf <= r_ovf | w_ovf;
                    r_unf <= r_unf | w_unf;
                    if (r_count != CNT_MAX) r_count <= r_count + CNT_W'(1);
                end
            end
        end
    end

    assign in_ready      = w_in_ready;
    assign out_valid     = (r_state == HOLD);
    assign out_sum       = r_acc;
    assign out_count     = r_count;
    assign out_overflow  = r_ovf;
    assign out_underflow = r_unf;
endmodule

// File: tb/tb_fp_accumulator.sv
// Directed bench for fp_accumulator; expected packet results go through a queue.
module tb_fp_accumulator;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0, in_sub = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [31:0]      in_data = '0;
    logic             in_ready, out_valid, out_overflow, out_underflow;
    logic [31:0]      out_sum;
    logic [CNT_W-1:0] out_count;

    fp_accumulator #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sub(in_sub), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_count(out_count), .out_overflow(out_overflow), .out_underflow(out_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      sum;
        logic [CNT_W-1:0] cnt;
        logic             ov;
        logic             uf;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic expect_pkt(input logic [31:0] s, input int c, input logic ov, input logic uf);
        exp_t e;
        e.sum = s; e.cnt = CNT_W'(c); e.ov = ov; e.uf = uf;
        sb_q.push_back(e);
    endtask

    task automatic send(input logic [31:0] d, input logic s, input logic l);
        int n;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_sub = s; in_last = l;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_sub = 1'b0; in_last = 1'b0;
    endtask

    // compare the held result against the oldest expectation
    task automatic check_out(input string tag);
        exp_t e;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({tag, "_sum"}, out_sum, e.sum);
            chk({tag, "_count"}, 32'(out_count), 32'(e.cnt));
            chk({tag, "_ovf"}, 32'(out_overflow), 32'(e.ov));
            chk({tag, "_unf"}, 32'(out_underflow), 32'(e.uf));
        end
    endtask

    task automatic drain(input string tag);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        chk({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held_sum;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", out_sum, 32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_flags", {30'd0, out_overflow, out_underflow}, 32'd0);
        @(negedge clk); rst = 1'b0; #1;
        chk("rst_rel_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("rst_rel_in_ready_high", 32'(in_ready), 32'd1);

        expect_pkt(32'h40C00000, 3, 1'b0, 1'b0);
        send(32'h3F800000, 1'b0, 1'b0);
        chk("p123_no_early_valid", 32'(out_valid), 32'd0);
        send(32'h40000000, 1'b0, 1'b0);
        send(32'h40400000, 1'b0, 1'b1);
        check_out("p123"); drain("p123");

        expect_pkt(32'h40400000, 2, 1'b0, 1'b0);
        send(32'h40A00000, 1'b0, 1'b0);
        send(32'h40000000, 1'b1, 1'b1);
        check_out("p5m2"); drain("p5m2");

        expect_pkt(32'hBF800000, 1, 1'b0, 1'b0);
        send(32'h3F800000, 1'b1, 1'b1);
        check_out("single_neg"); drain("single_neg");

        expect_pkt(32'h7F800000, 2, 1'b1, 1'b0);
        send(32'h7F000000, 1'b0, 1'b0);
        send(32'h7F000000, 1'b0, 1'b1);
        check_out("ovf");
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            chk("ovf_hold_flag", 32'(out_overflow), 32'd1);
            chk("ovf_hold_valid", 32'(out_valid), 32'd1);
        end
        drain("ovf");

        expect_pkt(32'h40000000, 1, 1'b0, 1'b0);
        send(32'h40000000, 1'b0, 1'b1);
        check_out("flags_cleared"); drain("flags_cleared");

        // ties to even: 1 + 2^-24 stays 1.0, odd lsb rounds up
        expect_pkt(32'h3F800000, 2, 1'b0, 1'b0);
        send(32'h3F800000, 1'b0, 1'b0);
        send(32'h33800000, 1'b0, 1'b1);
        check_out("tie_even"); drain("tie_even");
        expect_pkt(32'h3F800002, 2, 1'b0, 1'b0);
        send(32'h3F800001, 1'b0, 1'b0);
        send(32'h33800000, 1'b0, 1'b1);
        check_out("tie_odd"); drain("tie_odd");

        expect_pkt(32'h007FFFFF, 2, 1'b0, 1'b1);
        send(32'h00800000, 1'b0, 1'b0);
        send(32'h00000001, 1'b1, 1'b1);
        check_out("unf"); drain("unf");

        // backpressure in HOLD with an element already waiting
        expect_pkt(32'h3F800000, 1, 1'b0, 1'b0);
        expect_pkt(32'h40000000, 1, 1'b0, 1'b0);
        send(32'h3F800000, 1'b0, 1'b1);
        check_out("hold_first");
        held_sum = out_sum;
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'h40000000; in_last = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_sum", out_sum, held_sum);
            chk("hold_count", 32'(out_count), 32'd1);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        chk("hold_release_valid", 32'(out_valid), 32'd0);
        chk("hold_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        check_out("hold_pending"); drain("hold_pending");

        expect_pkt(32'h00000000, 255, 1'b0, 1'b0);
        for (int k = 0; k < 259; k++) send(32'h00000000, 1'b0, 1'b0);
        send(32'h00000000, 1'b0, 1'b1);
        check_out("sat"); drain("sat");

        send(32'h3F800000, 1'b0, 1'b0);
        send(32'h40000000, 1'b0, 1'b0);
        #2 rst = 1'b1; #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", out_sum, 32'd0);
        chk("midrst_count", 32'(out_count), 32'd0);
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("midrst_no_output", 32'(out_valid), 32'd0);
        end
        expect_pkt(32'h3F800000, 1, 1'b0, 1'b0);
        send(32'h3F800000, 1'b0, 1'b1);
        check_out("after_rst"); drain("after_rst");

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
